// File: rtl/red_iterativa_secuencial_pkg.sv
`default_nettype none
// ============================================================================
//  red_iterativa_pkg
//  Shared FSM encoding, scan-direction constants and digit-count helper.
//  Revision: 1.0
// ============================================================================
package red_iterativa_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_IaD = 1'b0;  // left-to-right, MSB digit first
    localparam logic DIR_DaI = 1'b1;  // right-to-left, LSB digit first

    function automatic int digit_count(input int n, input int w);
        return n / w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/red_iterativa_secuencial_if.sv
`default_nettype none
// ============================================================================
//  red_iterativa_secuencial_if
//  Start/busy/done handshake, operands and comparison flags of the comparator.
//  Revision: 1.0
// ============================================================================
interface red_iterativa_secuencial_if #(
    parameter int N = 32
) ();
    logic         start;
    logic         DIR;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         GT;
    logic         EQ;
    logic         LT;
    logic         Z_out;

    modport master (
        output start, DIR, A, B,
        input  busy, done, GT, EQ, LT, Z_out
    );

    modport slave (
        input  start, DIR, A, B,
        output busy, done, GT, EQ, LT, Z_out
    );
endinterface
`default_nettype wire

// File: rtl/red_iterativa_secuencial_celda_digito.sv
`default_nettype none
// ============================================================================
//  celda_digito
//  Combinational W-bit digit comparator updating the X (A>B) / Y (A<B) flags.
//  Revision: 1.0
// ============================================================================
module celda_digito
    import red_iterativa_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] dA,
    input  logic [W-1:0] dB,
    input  logic         x,
    input  logic         y,
    input  logic         DIR,
    output logic         X,
    output logic         Y
);
    logic w_gt;
    logic w_lt;

    assign w_gt = (dA > dB);
    assign w_lt = (dA < dB);

    // MSB-first keeps the first decision; LSB-first lets each later,
    // more significant unequal digit overwrite the earlier verdict.
    always_comb begin
        X = x;
        Y = y;
        if (DIR == DIR_IaD) begin
            if (!(x | y)) begin
                X = w_gt;
                Y = w_lt;
            end
        end else if (dA != dB) begin
            X = w_gt;
            Y = w_lt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/red_iterativa_secuencial.sv
`default_nettype none
// ============================================================================
//  red_iterativa_secuencial
//  Sequential N-bit unsigned comparator reusing one W-bit digit cell over N/W
//  cycles, with run-time scan direction. Optional macro:
//  RED_ITERATIVA_EARLY_EXIT_EN (MSB-first scan stops at the first decision).
//  Revision: 1.0
// ============================================================================
module red_iterativa_secuencial
    import red_iterativa_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    red_iterativa_secuencial_if.slave   bus
);
    localparam int c_K  = digit_count(N, W);
    localparam int c_CW = $clog2(c_K + 1);

    generate
        if ((N < 4) || ((N % W) != 0)) begin : g_param_check
            $error("red_iterativa_secuencial: N must be >= 4 and a multiple of W");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_dir;
    logic [c_CW-1:0] r_cnt;
    logic            r_x;
    logic            r_y;
    logic            r_gt;
    logic            r_eq;
    logic            r_lt;
    logic            r_done;
    logic [W-1:0]    w_da;
    logic [W-1:0]    w_db;
    logic            w_x;
    logic            w_y;
    logic            w_last;
    logic            w_exit;

    assign w_da = (r_dir == DIR_DaI) ? r_a[W-1:0] : r_a[N-1 -: W];
    assign w_db = (r_dir == DIR_DaI) ? r_b[W-1:0] : r_b[N-1 -: W];

    celda_digito #(.W(W)) u_celda (
        .dA  (w_da),
        .dB  (w_db),
        .x   (r_x),
        .y   (r_y),
        .DIR (r_dir),
        .X   (w_x),
        .Y   (w_y)
    );

    assign w_last = (r_cnt == c_CW'(c_K - 1));

`ifdef RED_ITERATIVA_EARLY_EXIT_EN
    assign w_exit = w_last | ((r_dir == DIR_IaD) & (w_x | w_y));
`else
    assign w_exit = w_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_exit)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_dir   <= DIR_IaD;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.A;
                        r_b   <= bus.B;
                        r_dir <= bus.DIR;
                        r_cnt <= '0;
                        r_x   <= 1'b0;
                        r_y   <= 1'b0;
                    end
                end
                RUN: begin
                    r_x   <= w_x;
                    r_y   <= w_y;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_dir == DIR_DaI) begin
                        r_a <= r_a >> W;
                        r_b <= r_b >> W;
                    end else begin
                        r_a <= r_a << W;
                        r_b <= r_b << W;
                    end
                    if (w_exit) begin
                        r_gt   <= w_x;
                        r_lt   <= w_y;
                        r_eq   <= ~(w_x | w_y);
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (r_state == RUN);
    assign bus.done  = r_done;
    assign bus.GT    = r_gt;
    assign bus.EQ    = r_eq;
    assign bus.LT    = r_lt;
    assign bus.Z_out = ~r_gt;
endmodule
`default_nettype wire

// File: tb/tb_red_iterativa_secuencial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_red_iterativa_secuencial
//  Vector table plus scoreboard bench for the N=8/W=1 and N=32/W=4 builds.
//  Revision: 1.0
// ============================================================================
module tb_red_iterativa_secuencial;

    typedef struct {
        bit          big;   // 0: N=8 W=1 instance, 1: N=32 W=4 instance
        logic        dir;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  res;   // {GT, EQ, LT}
    } vec_t;

    typedef struct {
        logic [2:0] res;
        longint     cyc;    // cycle at which done must be visible
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     done8_cnt = 0;
    exp_t   q8[$];
    exp_t   q32[$];
    exp_t   e8, e32;
    vec_t   tbl[12];
    vec_t   rv;
    int     d0;
    int     mode;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    red_iterativa_secuencial_if #(.N(8))  b8 ();
    red_iterativa_secuencial_if #(.N(32)) b32 ();

    red_iterativa_secuencial #(.N(8),  .W(1)) u8  (.clk(clk), .rst(rst), .bus(b8));
    red_iterativa_secuencial #(.N(32), .W(4)) u32 (.clk(clk), .rst(rst), .bus(b32));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Cycles from capture to done; early exit stops MSB-first scans at the first unequal digit.
    function automatic int exp_lat(input int n, input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic dir);
        int k;
        k = n / w;
`ifdef RED_ITERATIVA_EARLY_EXIT_EN
        if (dir == 1'b0) begin
            for (int i = 0; i < k; i++) begin
                logic [31:0] m;
                m = (32'd1 << w) - 32'd1;
                if (((a >> (n - w * (i + 1))) & m) != ((b >> (n - w * (i + 1))) & m))
                    return i + 1;
            end
        end
`endif
        return k;
    endfunction

    always @(negedge clk) begin
        if (b8.done) begin
            done8_cnt++;
            if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                chk("res8",  {61'd0, b8.GT, b8.EQ, b8.LT}, {61'd0, e8.res});
                chk("zout8", {63'd0, b8.Z_out}, {63'd0, ~e8.res[2]});
                chk("lat8",  cyc, e8.cyc);
                chk("busy8_done", {63'd0, b8.busy}, 64'd0);
            end
        end
        if (b32.done) begin
            if (q32.size() == 0) chk("done32_unexpected", 64'd1, 64'd0);
            else begin
                e32 = q32.pop_front();
                chk("res32",  {61'd0, b32.GT, b32.EQ, b32.LT}, {61'd0, e32.res});
                chk("zout32", {63'd0, b32.Z_out}, {63'd0, ~e32.res[2]});
                chk("lat32",  cyc, e32.cyc);
                chk("busy32_done", {63'd0, b32.busy}, 64'd0);
            end
        end
    end

    task automatic wait_idle(input bit big);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((big ? q32.size() : q8.size()) == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("done_timeout", 64'd1, 64'd0);
            if (big) q32.delete(); else q8.delete();
        end
    endtask

    task automatic go(input vec_t v);
        int   lat;
        exp_t e;
        lat = v.big ? exp_lat(32, 4, v.a, v.b, v.dir) : exp_lat(8, 1, v.a, v.b, v.dir);
        @(negedge clk);
        if (v.big) begin
            b32.A = v.a; b32.B = v.b; b32.DIR = v.dir; b32.start = 1'b1;
        end else begin
            b8.A = v.a[7:0]; b8.B = v.b[7:0]; b8.DIR = v.dir; b8.start = 1'b1;
        end
        @(posedge clk);
        #1;
        e.res = v.res;
        e.cyc = cyc + lat;
        // Scramble the inputs: the captured operands alone must decide the result.
        if (v.big) begin
            q32.push_back(e);
            b32.start = 1'b0; b32.A = ~v.a; b32.B = ~v.b; b32.DIR = ~v.dir;
        end else begin
            q8.push_back(e);
            b8.start = 1'b0; b8.A = ~v.a[7:0]; b8.B = ~v.b[7:0]; b8.DIR = ~v.dir;
        end
        @(negedge clk);
        chk("busy_run", {63'd0, v.big ? b32.busy : b8.busy}, 64'd1);
        wait_idle(v.big);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1'b0, 32'h80,       32'h7F,       3'b100};
        tbl[1]  = '{0, 1'b1, 32'h01,       32'h80,       3'b001};
        tbl[2]  = '{0, 1'b0, 32'h55,       32'h55,       3'b010};
        tbl[3]  = '{0, 1'b1, 32'h55,       32'h55,       3'b010};
        tbl[4]  = '{0, 1'b1, 32'hFF,       32'h00,       3'b100};
        tbl[5]  = '{0, 1'b0, 32'h00,       32'hFF,       3'b001};
        tbl[6]  = '{0, 1'b1, 32'h7F,       32'h80,       3'b001};
        tbl[7]  = '{1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 3'b010};
        tbl[8]  = '{1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 3'b010};
        tbl[9]  = '{1, 1'b0, 32'h00000001, 32'h00000000, 3'b100};
        tbl[10] = '{1, 1'b1, 32'h10000000, 32'h0FFFFFFF, 3'b100};
        tbl[11] = '{1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'b001};

        b8.start = 1'b0;  b8.DIR = 1'b0;  b8.A = '0;  b8.B = '0;
        b32.start = 1'b0; b32.DIR = 1'b0; b32.A = '0; b32.B = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset8",  {58'd0, b8.busy, b8.done, b8.GT, b8.EQ, b8.LT, b8.Z_out}, 64'b000001);
        chk("reset32", {58'd0, b32.busy, b32.done, b32.GT, b32.EQ, b32.LT, b32.Z_out}, 64'b000001);
        rst = 1'b0;

        foreach (tbl[i]) go(tbl[i]);

        for (int i = 0; i < 300; i++) begin
            rv.big = 1'($urandom_range(0, 1));
            rv.dir = 1'($urandom_range(0, 1));
            rv.a   = $urandom;
            rv.b   = $urandom;
            mode   = $urandom_range(0, 2);
            if (mode == 1) rv.b = rv.a;
            if (mode == 2) rv.b = rv.a ^ (32'd1 << $urandom_range(0, 31));
            if (!rv.big) begin
                rv.a = rv.a & 32'hFF;
                rv.b = rv.b & 32'hFF;
            end
            rv.res = {rv.a > rv.b, rv.a == rv.b, rv.a < rv.b};
            go(rv);
        end

        // Reset in the 3rd RUN cycle aborts; a start alongside reset is lost.
        @(negedge clk);
        b8.A = 8'h35; b8.B = 8'h36; b8.DIR = 1'b0; b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        d0 = done8_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1; b8.start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; b8.start = 1'b0;
        chk("abort_outputs", {58'd0, b8.busy, b8.done, b8.GT, b8.EQ, b8.LT, b8.Z_out}, 64'b000001);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done8_cnt - d0), 64'd0);
        chk("abort_idle", {63'd0, b8.busy}, 64'd0);
        rv = '{0, 1'b0, 32'h35, 32'h36, 3'b001};
        go(rv);

        // Start held high: accepted at capture and again K+1 edges later.
        @(negedge clk);
        b8.A = 8'h10; b8.B = 8'h10; b8.DIR = 1'b0; b8.start = 1'b1;
        @(posedge clk);
        #1;
        d0 = done8_cnt;
        q8.push_back('{3'b010, cyc + 8});
        for (int i = 1; i < 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) q8.push_back('{3'b010, cyc + 8});
        end
        b8.start = 1'b0;
        wait_idle(1'b0);
        repeat (4) @(negedge clk);
        chk("held_done_count", 64'(done8_cnt - d0), 64'd2);
        chk("hold8", {61'd0, b8.GT, b8.EQ, b8.LT}, 64'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
